// File: rtl/mips_pkg.sv
// Shared encodings, ALU operation set and pipeline-register layouts for the
// five-stage MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ifid_t;

    // An all-zero record is a bubble: no write, no strobe, no branch.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_beq;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } exmem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  dst;
        logic        reg_write;
    } memwb_t;

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips_reg_file.sv
// 32-bit general register file: two async read ports, one write port, r0 reads
// zero, and a same-cycle write is bypassed to the readers.
module mips_reg_file #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    logic [31:0] r_regs [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != 5'd0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 :
                       (i_we && i_waddr == i_raddr_a) ? i_wdata : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 :
                       (i_we && i_waddr == i_raddr_b) ? i_wdata : r_regs[i_raddr_b];

endmodule

// File: rtl/mips5_pipeline_cpu.sv
// Five-stage MIPS integer core: jumps resolve in ID, beq in EX, operands are
// forwarded from EX/MEM then MEM/WB, and a load-use pair costs one bubble.
module mips5_pipeline_cpu
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] inst_adr,
    output logic [31:0] data_adr,
    output logic [31:0] data_out
);
    logic [31:0] r_pc;
    ifid_t       r_ifid;
    idex_t       r_idex, w_dec;
    exmem_t      r_exmem, w_exmem_nxt;
    memwb_t      r_memwb, w_memwb_nxt;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm, w_rs_val, w_rt_val;
    logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_br_tgt, w_j_tgt;
    logic        w_beq_taken, w_load_use, w_jump;

    assign w_op  = r_ifid.inst[31:26];
    assign w_rs  = r_ifid.inst[25:21];
    assign w_rt  = r_ifid.inst[20:16];
    assign w_rd  = r_ifid.inst[15:11];
    assign w_fn  = r_ifid.inst[5:0];
    assign w_imm = {{16{r_ifid.inst[15]}}, r_ifid.inst[15:0]};

    mips_reg_file #(.DEPTH(RF_DEPTH)) u_rf (
        .clk       (clk),
        .rst_n     (rst),
        .i_we      (r_memwb.reg_write),
        .i_waddr   (r_memwb.dst),
        .i_wdata   (r_memwb.result),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_val),
        .o_rdata_b (w_rt_val)
    );

    // Unknown opcodes and functs leave all control bits clear, i.e. a NOP.
    always_comb begin
        w_dec        = '0;
        w_dec.pc4    = r_ifid.pc4;
        w_dec.rs     = w_rs;
        w_dec.rt     = w_rt;
        w_dec.rs_val = w_rs_val;
        w_dec.rt_val = w_rt_val;
        w_dec.imm    = w_imm;
        w_dec.alu_op = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                w_dec.dst       = w_rd;
                w_dec.reg_write = 1'b1;
                case (w_fn)
                    FN_ADD:  w_dec.alu_op = ALU_ADD;
                    FN_SUB:  w_dec.alu_op = ALU_SUB;
                    FN_AND:  w_dec.alu_op = ALU_AND;
                    FN_OR:   w_dec.alu_op = ALU_OR;
                    FN_SLT:  w_dec.alu_op = ALU_SLT;
                    default: w_dec.reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                w_dec.dst       = w_rt;
                w_dec.reg_write = 1'b1;
                w_dec.use_imm   = 1'b1;
                w_dec.alu_op    = (w_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            OP_LW: begin
                w_dec.dst       = w_rt;
                w_dec.reg_write = 1'b1;
                w_dec.use_imm   = 1'b1;
                w_dec.mem_read  = 1'b1;
            end
            OP_SW: begin
                w_dec.use_imm   = 1'b1;
                w_dec.mem_write = 1'b1;
            end
            OP_BEQ:  w_dec.is_beq = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_fwd_a = r_idex.rs_val;
        if (r_exmem.reg_write && r_exmem.dst != 5'd0 && r_exmem.dst == r_idex.rs)
            w_fwd_a = r_exmem.alu_res;
        else if (r_memwb.reg_write && r_memwb.dst != 5'd0 && r_memwb.dst == r_idex.rs)
            w_fwd_a = r_memwb.result;
        w_fwd_b = r_idex.rt_val;
        if (r_exmem.reg_write && r_exmem.dst != 5'd0 && r_exmem.dst == r_idex.rt)
            w_fwd_b = r_exmem.alu_res;
        else if (r_memwb.reg_write && r_memwb.dst != 5'd0 && r_memwb.dst == r_idex.rt)
            w_fwd_b = r_memwb.result;
    end

    assign w_alu_b     = r_idex.use_imm ? r_idex.imm : w_fwd_b;
    assign w_beq_taken = r_idex.is_beq && (w_fwd_a == w_fwd_b);
    assign w_br_tgt    = r_idex.pc4 + {r_idex.imm[29:0], 2'b00};
    assign w_j_tgt     = {r_ifid.pc4[31:28], r_ifid.inst[25:0], 2'b00};
    assign w_load_use  = r_idex.mem_read && r_idex.rt != 5'd0 &&
                         (r_idex.rt == w_rs || r_idex.rt == w_rt);
    assign w_jump      = (w_op == OP_J) && !w_load_use;

    always_comb begin
        w_exmem_nxt.alu_res   = alu(r_idex.alu_op, w_fwd_a, w_alu_b);
        w_exmem_nxt.st_data   = w_fwd_b;
        w_exmem_nxt.dst       = r_idex.dst;
        w_exmem_nxt.reg_write = r_idex.reg_write;
        w_exmem_nxt.mem_read  = r_idex.mem_read;
        w_exmem_nxt.mem_write = r_idex.mem_write;
        w_memwb_nxt.result    = r_exmem.mem_read ? data_in : r_exmem.alu_res;
        w_memwb_nxt.dst       = r_exmem.dst;
        w_memwb_nxt.reg_write = r_exmem.reg_write;
    end

    // Redirect priority: taken beq flush, then load-use hold, then jump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_ifid  <= '0;
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else begin
            r_exmem <= w_exmem_nxt;
            r_memwb <= w_memwb_nxt;
            if (w_beq_taken) begin
                r_pc   <= w_br_tgt;
                r_ifid <= '0;
                r_idex <= '0;
            end else if (w_load_use) begin
                r_idex <= '0;
            end else if (w_jump) begin
                r_pc   <= w_j_tgt;
                r_ifid <= '0;
                r_idex <= w_dec;
            end else begin
                r_pc   <= r_pc + 32'd4;
                r_ifid <= '{pc4: r_pc + 32'd4, inst: inst};
                r_idex <= w_dec;
            end
        end
    end

    assign inst_adr  = r_pc;
    assign mem_read  = r_exmem.mem_read;
    assign mem_write = r_exmem.mem_write;
    assign data_adr  = r_exmem.alu_res;
    assign data_out  = r_exmem.st_data;

endmodule

// File: tb/tb_mips5_pipeline_cpu.sv
// Bench for mips5_pipeline_cpu: a directed program checked cycle by cycle
// from a table, a mid-run reset sequence, and random programs compared against
// an instruction-level interpreter.
module tb_mips5_pipeline_cpu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, data_in, inst_adr, data_adr, data_out;
    logic        mem_read, mem_write;

    logic [31:0] imem [128];
    logic [31:0] dmem [64];
    logic [31:0] mdl_mem [64];
    logic [63:0] exp_q [$];
    logic [63:0] act_q [$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign inst    = (inst_adr[31:9] == 23'd0) ? imem[inst_adr[8:2]] : 32'h0;
    assign data_in = dmem[data_adr[7:2]];
    always @(posedge clk) if (mem_write) dmem[data_adr[7:2]] = data_out;

    mips5_pipeline_cpu #(.RESET_PC(32'h0), .RF_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .inst(inst), .data_in(data_in),
        .mem_read(mem_read), .mem_write(mem_write), .inst_adr(inst_adr),
        .data_adr(data_adr), .data_out(data_out)
    );

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs,
                                          input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs,
                                          input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_ins(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_rst();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cyc = 0;
    endtask

    // Architectural interpreter: executes the program in imem until the PC
    // leaves the first n words, recording every store in order.
    task automatic run_model(input int n);
        logic [31:0] rf [32];
        logic [31:0] pc, npc, ins, a, b, simm, res, ea;
        logic [5:0]  op;
        int dst, steps;
        bit wr;
        for (int i = 0; i < 32; i++) rf[i] = 0;
        pc = 0;
        steps = 0;
        exp_q.delete();
        while (pc < 32'(n * 4) && steps < 1000) begin
            ins  = imem[pc[8:2]];
            op   = ins[31:26];
            a    = rf[ins[25:21]];
            b    = rf[ins[20:16]];
            simm = {{16{ins[15]}}, ins[15:0]};
            ea   = a + simm;
            npc  = pc + 4;
            wr   = 0;
            dst  = ins[20:16];
            res  = 0;
            case (op)
                6'h00: begin
                    dst = ins[15:11];
                    wr  = 1;
                    case (ins[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
                        default: wr = 0;
                    endcase
                end
                6'h08: begin wr = 1; res = ea; end
                6'h0A: begin wr = 1; res = ($signed(a) < $signed(simm)) ? 1 : 0; end
                6'h23: begin wr = 1; res = mdl_mem[ea[7:2]]; end
                6'h2B: begin
                    mdl_mem[ea[7:2]] = b;
                    exp_q.push_back({ea, b});
                end
                6'h04: if (a == b) npc = pc + 4 + (simm << 2);
                6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
                default: ;
            endcase
            if (wr && dst != 0) rf[dst] = res;
            pc = npc;
            steps++;
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        rd;
        logic        wr;
        logic        chk_d;
        logic [31:0] adr;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int strobes;
        int n;
        int k;
        int lim;
        logic [5:0] fns [5];

        tbl[0]  = '{0,  32'h000, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  32'h004, 0, 0, 0, 0, 0};
        tbl[2]  = '{2,  32'h008, 0, 0, 0, 0, 0};
        tbl[3]  = '{3,  32'h00C, 0, 0, 0, 0, 0};
        tbl[4]  = '{6,  32'h018, 0, 1, 1, 0, 13};
        tbl[5]  = '{7,  32'h01C, 0, 0, 0, 0, 0};
        tbl[6]  = '{9,  32'h024, 0, 0, 0, 0, 0};
        tbl[7]  = '{10, 32'h024, 1, 0, 1, 8, 0};
        tbl[8]  = '{11, 32'h028, 0, 0, 0, 0, 0};
        tbl[9]  = '{12, 32'h02C, 0, 0, 0, 0, 0};
        tbl[10] = '{13, 32'h100, 0, 1, 1, 4, 14};
        tbl[11] = '{14, 32'h104, 0, 0, 0, 0, 0};
        tbl[12] = '{15, 32'h108, 0, 0, 0, 0, 0};
        tbl[13] = '{17, 32'h110, 0, 1, 1, 12, 0};
        tbl[14] = '{18, 32'h114, 0, 0, 0, 0, 0};
        tbl[15] = '{21, 32'h120, 0, 1, 1, 16, 1};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // Directed program: forwarding, beq flush, load-use, jump, r0, slt.
        rst = 1'b0;
        for (int i = 0; i < 128; i++) imem[i] = 0;
        for (int i = 0; i < 64; i++) dmem[i] = 0;
        dmem[2] = 32'd7;
        dmem[3] = 32'h1111_1111;
        dmem[5] = 32'hDEAD_BEEF;
        imem[0]  = i_ins(6'h08, 1, 0, 5);
        imem[1]  = i_ins(6'h08, 2, 1, 3);
        imem[2]  = r_ins(6'h20, 3, 1, 2);
        imem[3]  = i_ins(6'h2B, 3, 0, 0);
        imem[4]  = i_ins(6'h04, 1, 1, 2);
        imem[5]  = i_ins(6'h08, 9, 0, 1);
        imem[6]  = i_ins(6'h2B, 1, 0, 16);
        imem[7]  = i_ins(6'h23, 4, 0, 8);
        imem[8]  = r_ins(6'h20, 5, 4, 4);
        imem[9]  = i_ins(6'h2B, 5, 0, 4);
        imem[10] = j_ins(32'h40);
        imem[11] = i_ins(6'h2B, 1, 0, 20);
        imem[64] = r_ins(6'h20, 0, 1, 1);
        imem[65] = i_ins(6'h2B, 0, 0, 12);
        imem[66] = i_ins(6'h08, 7, 0, -1);
        imem[67] = i_ins(6'h08, 8, 0, 1);
        imem[68] = r_ins(6'h2A, 6, 7, 8);
        imem[69] = i_ins(6'h2B, 6, 0, 16);
        #3;
        chk("reset inst_adr", inst_adr, 32'h0);
        chk("reset mem_read", {31'b0, mem_read}, 32'h0);
        chk("reset mem_write", {31'b0, mem_write}, 32'h0);
        chk("reset data_adr", data_adr, 32'h0);
        chk("reset data_out", data_out, 32'h0);
        @(negedge clk);
        chk("reset hold inst_adr", inst_adr, 32'h0);
        chk("reset hold mem_write", {31'b0, mem_write}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            while (cyc < tbl[i].cyc) step();
            chk($sformatf("c%0d inst_adr", cyc), inst_adr, tbl[i].pc);
            chk($sformatf("c%0d mem_read", cyc), {31'b0, mem_read}, {31'b0, tbl[i].rd});
            chk($sformatf("c%0d mem_write", cyc), {31'b0, mem_write}, {31'b0, tbl[i].wr});
            if (tbl[i].chk_d) begin
                chk($sformatf("c%0d data_adr", cyc), data_adr, tbl[i].adr);
                chk($sformatf("c%0d data_out", cyc), data_out, tbl[i].dout);
            end
        end
        step();
        step();
        chk("dir mem[0]", dmem[0], 32'd13);
        chk("dir mem[1]", dmem[1], 32'd14);
        chk("dir mem[2]", dmem[2], 32'd7);
        chk("dir mem[3]", dmem[3], 32'd0);
        chk("dir mem[4]", dmem[4], 32'd1);
        chk("dir mem[5]", dmem[5], 32'hDEAD_BEEF);

        // Reset in the middle of a run discards an in-flight store.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) imem[i] = 0;
        dmem[0] = 32'h5555_5555;
        imem[0] = i_ins(6'h08, 1, 0, 9);
        imem[1] = i_ins(6'h2B, 1, 0, 0);
        release_rst();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst inst_adr", inst_adr, 32'h0);
        chk("midrst mem_write", {31'b0, mem_write}, 32'h0);
        imem[1] = 32'h0;
        strobes = 0;
        repeat (2) begin
            step();
            if (mem_write) strobes++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        cyc = 0;
        chk("midrst restart pc0", inst_adr, 32'h0);
        step();
        chk("midrst restart pc1", inst_adr, 32'h4);
        for (int i = 0; i < 8; i++) begin
            if (mem_write) strobes++;
            step();
        end
        chk("midrst strobes", 32'(strobes), 32'h0);
        chk("midrst mem[0]", dmem[0], 32'h5555_5555);

        // Random programs against the interpreter.
        n = 40;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 128; i++) imem[i] = 0;
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 9);
                case (k)
                    0, 1: imem[i] = ($urandom_range(0, 7) == 0) ?
                              r_ins(6'h27, $urandom_range(0, 7), $urandom_range(0, 7),
                                    $urandom_range(0, 7)) :
                              r_ins(fns[$urandom_range(0, 4)], $urandom_range(0, 7),
                                    $urandom_range(0, 7), $urandom_range(0, 7));
                    2: imem[i] = i_ins(6'h08, $urandom_range(0, 7), $urandom_range(0, 7),
                                       $urandom_range(0, 65535));
                    3: imem[i] = i_ins(6'h0A, $urandom_range(0, 7), $urandom_range(0, 7),
                                       $urandom_range(0, 65535));
                    4, 9: imem[i] = i_ins(6'h23, $urandom_range(0, 7), 0,
                                          4 * $urandom_range(0, 15));
                    5, 6: imem[i] = i_ins(6'h2B, $urandom_range(0, 7), 0,
                                          4 * $urandom_range(0, 15));
                    7: imem[i] = i_ins(6'h04, $urandom_range(0, 2), $urandom_range(0, 2),
                                       $urandom_range(0, 3));
                    default: imem[i] = ($urandom_range(0, 3) == 0) ? 32'hFC00_0000 :
                                       j_ins(i + 1 + $urandom_range(0, 2));
                endcase
            end
            for (int i = 0; i < 64; i++) begin
                dmem[i]    = $urandom;
                mdl_mem[i] = dmem[i];
            end
            run_model(n);
            act_q.delete();
            release_rst();
            for (int c = 0; c < 4 * n + 20; c++) begin
                if (mem_write) act_q.push_back({data_adr, data_out});
                step();
            end
            chk($sformatf("p%0d store count", p), 32'(act_q.size()), 32'(exp_q.size()));
            lim = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
            for (int i = 0; i < lim; i++) begin
                chk($sformatf("p%0d st%0d adr", p, i), act_q[i][63:32], exp_q[i][63:32]);
                chk($sformatf("p%0d st%0d data", p, i), act_q[i][31:0], exp_q[i][31:0]);
            end
            for (int i = 0; i < 64; i++)
                chk($sformatf("p%0d mem[%0d]", p, i), dmem[i], mdl_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips5_pipeline_cpu.md
Name: mips5_pipeline_cpu

Overview:
Five-stage (IF, ID, EX, MEM, WB) 32-bit MIPS integer core with forwarding, load-use stall and control-hazard flush. Harvard interface: fetch through inst_adr/inst, load/store through data_adr/data_in/data_out with mem_read/mem_write strobes. The instruction memory is combinational and external. The data memory is external, with combinational read and write on the clk rising edge. The core sits between these memories at the top of the CPU subsystem.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
RF_DEPTH, 32, number of general registers (r0 hardwired to zero).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
inst  input  32  instruction word at inst_adr, valid in the same cycle.
data_in  input  32  load data from data memory at data_adr, valid in the same cycle.
mem_read  output  1  load strobe, high while a lw is in MEM.
mem_write  output  1  store strobe, high while a sw is in MEM; memory writes at the next rising edge.
inst_adr  output  32  current PC, byte address.
data_adr  output  32  effective address (ALU result) of the instruction in MEM.
data_out  output  32  store data (forwarded rt value) of the instruction in MEM.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC; all pipeline registers cleared to bubble; register file cleared. Outputs: inst_adr=RESET_PC; mem_read=mem_write=0; data_adr=data_out=0. A reset asserted mid-run discards all in-flight instructions.
- ISA subset:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed compare).
  - I-type: addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
  - All other encodings, including 32'h0, execute as a NOP: no register write, no memory strobe.
- Arithmetic: 32-bit wrap-around with no overflow trap. Immediates are sign-extended. Writes to r0 are ignored and r0 always reads 0.
- IF: fetches inst at PC. Normally PC <= PC+4.
- ID:
  - Decodes the instruction and reads the register file. A register written in WB in the same cycle is bypassed to the read port.
  - j is resolved here: PC <= {PC4[31:28], target26, 2'b00}, and the IF/ID register is flushed. Penalty is 1 bubble.
- EX:
  - Runs the ALU on forwarded operands. EX/MEM forwarding takes priority over MEM/WB forwarding. There is no forwarding from r0.
  - beq is resolved here: if taken, PC <= PC4 + (sext(imm)<<2), and IF/ID and ID/EX are flushed. Penalty is 2 bubbles.
- MEM: drives data_adr, data_out, mem_read and mem_write from the EX/MEM register.
- WB: writes the ALU result or data_in (captured in MEM/WB) to rd (R-type) or rt (I-type) at the rising edge.
- Load-use stall: when ID/EX holds a lw whose rt≠0 matches the rs or rt of the instruction in IF/ID, hold PC and IF/ID for one cycle and insert a bubble into ID/EX.
- Latency: an instruction fetched at cycle n writes back at the edge ending cycle n+4. Dependent ALU instructions run back-to-back with no stall.
- Simultaneous hazard events:
  - A taken beq in EX overrides a load-use stall and a j in ID in the same cycle; the flush wins.
  - A j in ID during a load-use stall is held and not taken until the stall clears.
- PC wraps modulo 2^32.

Decomposition:
- Package mips_pkg: opcode and funct localparams, ALU-op enum (ADD, SUB, AND, OR, SLT), pipeline-register struct typedefs.
- One sub-module: mips_reg_file (32x32, two async read ports, one sync write port, async active-low clear, write-to-read bypass).
- Hazard and forwarding logic stays inline in the core.

Test Plan:
- Reset: hold rst=0 for 20 ns, then release → inst_adr=0 during reset, then inst_adr steps 0,4,8 per clock; mem_read=mem_write=0 throughout reset.
- Forwarding: addi r1,r0,5; addi r2,r1,3; add r3,r1,r2; sw r3,0(r0) → no stall; at the sw's MEM cycle mem_write=1, data_adr=0, data_out=13.
- Load-use: data memory word 8 holds 7; lw r4,8(r0); add r5,r4,r4; sw r5,4(r0) → exactly one stall cycle (inst_adr repeats once); store writes 14 to address 4.
- Branch: with r1=r2, beq r1,r2,+2 at address 0x10 → the instructions at 0x14 and 0x18 produce no writes; the next fetch is from 0x1C.
- Jump: j 0x40 at address 0x20 → the instruction at 0x24 is flushed; the next fetch after that is from 0x100.
- Misc: add r0,r1,r1 followed by sw r0,0(r0) → stores 0. slt r6,r7,r8 with r7=-1, r8=1 → r6=1. Reset asserted mid-program → in-flight sw never strobes, PC returns to 0.
